// File: rtl/mem_op_pkg.sv
// Shared definitions for the memory-access stage: load/store op codes,
// FSM state encoding and op-classification helpers.
package mem_op_pkg;

  localparam logic [7:0] OP_LB  = 8'h20;
  localparam logic [7:0] OP_LBU = 8'h21;
  localparam logic [7:0] OP_LH  = 8'h22;
  localparam logic [7:0] OP_LHU = 8'h23;
  localparam logic [7:0] OP_LW  = 8'h24;
  localparam logic [7:0] OP_SB  = 8'h28;
  localparam logic [7:0] OP_SH  = 8'h29;
  localparam logic [7:0] OP_SW  = 8'h2B;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } mem_state_t;

  function automatic logic is_load(input logic [7:0] op);
    return (op == OP_LB) || (op == OP_LBU) || (op == OP_LH) ||
           (op == OP_LHU) || (op == OP_LW);
  endfunction

  function automatic logic is_store(input logic [7:0] op);
    return (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane steering: builds store lane enables/data, extends load data and
// flags misaligned halfword/word accesses.
module mem_lane_align
  import mem_op_pkg::*;
(
  input  logic [7:0]  op,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] store_data,
  input  logic [31:0] load_word,
  output logic [3:0]  sel,
  output logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic        misalign
);

  logic [7:0]  load_bytes [4];
  logic [7:0]  byte_pick;
  logic [15:0] half_pick;

  for (genvar gi = 0; gi < 4; gi++) begin : g_lanes
    assign load_bytes[gi] = load_word[8*gi +: 8];
  end

  assign byte_pick = load_bytes[addr_lo];
  assign half_pick = addr_lo[1] ? load_word[31:16] : load_word[15:0];

  always_comb begin
    sel       = 4'b1111;
    wdata     = store_data;
    load_data = load_word;
    misalign  = 1'b0;
    case (op)
      OP_LB:  load_data = {{24{byte_pick[7]}}, byte_pick};
      OP_LBU: load_data = {24'h0, byte_pick};
      OP_LH: begin
        load_data = {{16{half_pick[15]}}, half_pick};
        misalign  = addr_lo[0];
      end
      OP_LHU: begin
        load_data = {16'h0, half_pick};
        misalign  = addr_lo[0];
      end
      OP_LW:  misalign = (addr_lo != 2'b00);
      OP_SB: begin
        sel   = 4'b0001 << addr_lo;
        wdata = {4{store_data[7:0]}};
      end
      OP_SH: begin
        sel      = addr_lo[1] ? 4'b1100 : 4'b0011;
        wdata    = {2{store_data[15:0]}};
        misalign = addr_lo[0];
      end
      OP_SW:  misalign = (addr_lo != 2'b00);
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_access_stage.sv
// MEM stage: runs loads/stores over a req/ack bus, stalls upstream while an
// access is outstanding, and registers the write-back triple for WB.
module mem_access_stage
  import mem_op_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  aluop_MEM,
  input  logic [31:0] mem_address_MEM,
  input  logic [31:0] reg_operation2_value_MEM,
  input  logic        is_write_MEM,
  input  logic [4:0]  write_regAddress_MEM,
  input  logic [31:0] write_regValue_MEM,
  output logic        mem_req,
  output logic        mem_we,
  output logic [3:0]  mem_sel,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        stall_req,
  output logic        is_write_WB,
  output logic [4:0]  write_regAddress_WB,
  output logic [31:0] write_regValue_WB,
  output logic        misalign_err,
  output logic        bus_err
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES);

  mem_state_t       state_reg;
  logic [CNT_W-1:0] wait_cnt_reg;
  logic [7:0]       op_kind_reg;
  logic [1:0]       addr_lo_reg;
  logic [4:0]       rd_reg;

  logic [7:0]  align_op;
  logic [1:0]  align_addr_lo;
  logic [3:0]  align_sel;
  logic [31:0] align_wdata;
  logic [31:0] align_load_data;
  logic        align_misalign;
  logic        is_mem_op;
  logic        timeout_hit;

  // In WAIT the aligner works on the latched op so load extension uses the
  // kind/offset captured at request time.
  assign align_op      = (state_reg == ST_WAIT) ? op_kind_reg : aluop_MEM;
  assign align_addr_lo = (state_reg == ST_WAIT) ? addr_lo_reg : mem_address_MEM[1:0];
  assign is_mem_op     = is_load(aluop_MEM) || is_store(aluop_MEM);
  assign timeout_hit   = (wait_cnt_reg == CNT_W'(TIMEOUT_CYCLES - 1));

  mem_lane_align u_align (
    .op         (align_op),
    .addr_lo    (align_addr_lo),
    .store_data (reg_operation2_value_MEM),
    .load_word  (mem_rdata),
    .sel        (align_sel),
    .wdata      (align_wdata),
    .load_data  (align_load_data),
    .misalign   (align_misalign)
  );

  // Gated by reset so stall drops the moment reset is asserted.
  always_comb begin
    stall_req = 1'b0;
    if (reset) begin
      case (state_reg)
        ST_IDLE: stall_req = is_mem_op && !align_misalign;
        ST_WAIT: stall_req = !mem_ack && !timeout_hit;
        default: stall_req = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg           <= ST_IDLE;
      wait_cnt_reg        <= '0;
      op_kind_reg         <= '0;
      addr_lo_reg         <= '0;
      rd_reg              <= '0;
      mem_req             <= 1'b0;
      mem_we              <= 1'b0;
      mem_sel             <= '0;
      mem_addr            <= '0;
      mem_wdata           <= '0;
      is_write_WB         <= 1'b0;
      write_regAddress_WB <= '0;
      write_regValue_WB   <= '0;
      misalign_err        <= 1'b0;
      bus_err             <= 1'b0;
    end else begin
      misalign_err <= 1'b0;
      bus_err      <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (!is_mem_op) begin
            is_write_WB         <= is_write_MEM;
            write_regAddress_WB <= write_regAddress_MEM;
            write_regValue_WB   <= write_regValue_MEM;
          end else if (align_misalign) begin
            misalign_err <= 1'b1;
            is_write_WB  <= 1'b0;
          end else begin
            mem_req      <= 1'b1;
            mem_we       <= is_store(aluop_MEM);
            mem_sel      <= align_sel;
            mem_addr     <= {mem_address_MEM[31:2], 2'b00};
            mem_wdata    <= align_wdata;
            op_kind_reg  <= aluop_MEM;
            addr_lo_reg  <= mem_address_MEM[1:0];
            rd_reg       <= write_regAddress_MEM;
            wait_cnt_reg <= '0;
            is_write_WB  <= 1'b0;
            state_reg    <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (mem_ack) begin
            if (is_load(op_kind_reg)) begin
              is_write_WB         <= 1'b1;
              write_regAddress_WB <= rd_reg;
              write_regValue_WB   <= align_load_data;
            end else begin
              is_write_WB <= 1'b0;
            end
            mem_req   <= 1'b0;
            state_reg <= ST_IDLE;
          end else if (timeout_hit) begin
            mem_req     <= 1'b0;
            bus_err     <= 1'b1;
            is_write_WB <= 1'b0;
            state_reg   <= ST_IDLE;
          end else begin
            wait_cnt_reg <= wait_cnt_reg + 1'b1;
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage: ALU pass-through, loads with extension,
// store lane steering, misalignment, bus timeout and reset mid-access.
module tb_mem_access_stage;
  import mem_op_pkg::*;

  localparam int T = 16;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  aluop_MEM;
  logic [31:0] mem_address_MEM;
  logic [31:0] reg_operation2_value_MEM;
  logic        is_write_MEM;
  logic [4:0]  write_regAddress_MEM;
  logic [31:0] write_regValue_MEM;
  logic        mem_req;
  logic        mem_we;
  logic [3:0]  mem_sel;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        stall_req;
  logic        is_write_WB;
  logic [4:0]  write_regAddress_WB;
  logic [31:0] write_regValue_WB;
  logic        misalign_err;
  logic        bus_err;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  mem_access_stage #(.TIMEOUT_CYCLES(T)) dut (
    .clk                      (clk),
    .reset                    (reset),
    .aluop_MEM                (aluop_MEM),
    .mem_address_MEM          (mem_address_MEM),
    .reg_operation2_value_MEM (reg_operation2_value_MEM),
    .is_write_MEM             (is_write_MEM),
    .write_regAddress_MEM     (write_regAddress_MEM),
    .write_regValue_MEM       (write_regValue_MEM),
    .mem_req                  (mem_req),
    .mem_we                   (mem_we),
    .mem_sel                  (mem_sel),
    .mem_addr                 (mem_addr),
    .mem_wdata                (mem_wdata),
    .mem_ack                  (mem_ack),
    .mem_rdata                (mem_rdata),
    .stall_req                (stall_req),
    .is_write_WB              (is_write_WB),
    .write_regAddress_WB      (write_regAddress_WB),
    .write_regValue_WB        (write_regValue_WB),
    .misalign_err             (misalign_err),
    .bus_err                  (bus_err)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic [7:0] op, input logic [31:0] addr, input logic [31:0] data,
                       input logic we, input logic [4:0] rd, input logic [31:0] val);
    aluop_MEM                = op;
    mem_address_MEM          = addr;
    reg_operation2_value_MEM = data;
    is_write_MEM             = we;
    write_regAddress_MEM     = rd;
    write_regValue_MEM       = val;
  endtask

  task automatic nop();
    drive(8'h00, 32'h0, 32'h0, 1'b0, 5'd0, 32'h0);
  endtask

  task automatic run_load(input string tag, input logic [7:0] op, input logic [31:0] addr,
                          input logic [31:0] exp_addr, input logic [4:0] rd,
                          input logic [31:0] rdata, input logic [31:0] exp);
    drive(op, addr, 32'h0, 1'b1, rd, 32'h5555_5555);
    #1 check({tag, ".stall_idle"}, 32'(stall_req), 32'd1);
    @(negedge clk);
    check({tag, ".req"}, 32'(mem_req), 32'd1);
    check({tag, ".addr"}, mem_addr, exp_addr);
    check({tag, ".sel"}, 32'(mem_sel), 32'hF);
    check({tag, ".we"}, 32'(mem_we), 32'd0);
    check({tag, ".bubble"}, 32'(is_write_WB), 32'd0);
    mem_ack   = 1'b1;
    mem_rdata = rdata;
    #1 check({tag, ".stall_ack"}, 32'(stall_req), 32'd0);
    @(negedge clk);
    mem_ack   = 1'b0;
    mem_rdata = 32'h0;
    check({tag, ".wb_we"}, 32'(is_write_WB), 32'd1);
    check({tag, ".wb_rd"}, 32'(write_regAddress_WB), 32'(rd));
    check({tag, ".wb_val"}, write_regValue_WB, exp);
    check({tag, ".req_drop"}, 32'(mem_req), 32'd0);
    nop();
    $display("load  %s addr=%h rdata=%h -> wb=%h", tag, addr, rdata, write_regValue_WB);
  endtask

  task automatic run_store(input string tag, input logic [7:0] op, input logic [31:0] addr,
                           input logic [31:0] data, input logic [31:0] exp_addr,
                           input logic [3:0] exp_sel, input logic [31:0] exp_wdata);
    drive(op, addr, data, 1'b1, 5'd4, 32'h0);
    #1 check({tag, ".stall_idle"}, 32'(stall_req), 32'd1);
    @(negedge clk);
    check({tag, ".req"}, 32'(mem_req), 32'd1);
    check({tag, ".we"}, 32'(mem_we), 32'd1);
    check({tag, ".addr"}, mem_addr, exp_addr);
    check({tag, ".sel"}, 32'(mem_sel), 32'(exp_sel));
    check({tag, ".wdata"}, mem_wdata, exp_wdata);
    mem_ack = 1'b1;
    @(negedge clk);
    mem_ack = 1'b0;
    check({tag, ".req_drop"}, 32'(mem_req), 32'd0);
    check({tag, ".wb_we"}, 32'(is_write_WB), 32'd0);
    nop();
    $display("store %s addr=%h data=%h sel=%b", tag, addr, data, exp_sel);
  endtask

  task automatic run_misalign(input string tag, input logic [7:0] op, input logic [31:0] addr);
    drive(op, addr, 32'h1111_2222, 1'b1, 5'd6, 32'h0);
    #1 check({tag, ".stall"}, 32'(stall_req), 32'd0);
    @(negedge clk);
    check({tag, ".err"}, 32'(misalign_err), 32'd1);
    check({tag, ".req"}, 32'(mem_req), 32'd0);
    check({tag, ".wb_we"}, 32'(is_write_WB), 32'd0);
    nop();
    @(negedge clk);
    check({tag, ".err_pulse"}, 32'(misalign_err), 32'd0);
    $display("misal %s addr=%h", tag, addr);
  endtask

  initial begin
    reset     = 1'b0;
    mem_ack   = 1'b0;
    mem_rdata = 32'h0;
    // a load presented during reset must not raise stall
    drive(OP_LW, 32'h100, 32'h0, 1'b1, 5'd1, 32'h0);
    repeat (2) @(negedge clk);
    check("rst.stall", 32'(stall_req), 32'd0);
    check("rst.req", 32'(mem_req), 32'd0);
    check("rst.wb_we", 32'(is_write_WB), 32'd0);
    check("rst.wb_val", write_regValue_WB, 32'h0);
    check("rst.errs", {30'h0, misalign_err, bus_err}, 32'h0);
    nop();
    reset = 1'b1;
    @(negedge clk);
    $display("reset released");

    drive(8'h01, 32'h0, 32'h0, 1'b1, 5'd5, 32'h1234);
    #1 check("add.stall", 32'(stall_req), 32'd0);
    @(negedge clk);
    check("add.wb_we", 32'(is_write_WB), 32'd1);
    check("add.wb_rd", 32'(write_regAddress_WB), 32'd5);
    check("add.wb_val", write_regValue_WB, 32'h1234);
    check("add.stall2", 32'(stall_req), 32'd0);
    nop();
    $display("alu   add -> wb r5=%h", write_regValue_WB);

    run_load("lw",  OP_LW,  32'h100, 32'h100, 5'd7,  32'hDEAD_BEEF, 32'hDEAD_BEEF);
    run_load("lb",  OP_LB,  32'h103, 32'h100, 5'd8,  32'h80FF_FF00, 32'hFFFF_FF80);
    run_load("lbu", OP_LBU, 32'h103, 32'h100, 5'd9,  32'h80FF_FF00, 32'h0000_0080);
    run_load("lh",  OP_LH,  32'h102, 32'h100, 5'd10, 32'h80FF_FF00, 32'hFFFF_80FF);
    run_load("lhu", OP_LHU, 32'h100, 32'h100, 5'd11, 32'h80FF_FF00, 32'h0000_FF00);

    run_store("sh", OP_SH, 32'h202, 32'hA5A5_1234, 32'h200, 4'b1100, 32'h1234_1234);
    run_store("sb", OP_SB, 32'h101, 32'h0000_00AB, 32'h100, 4'b0010, 32'hABAB_ABAB);
    run_store("sw", OP_SW, 32'h304, 32'h0BAD_F00D, 32'h304, 4'b1111, 32'h0BAD_F00D);

    run_misalign("lw_mis", OP_LW, 32'h101);
    run_misalign("sh_mis", OP_SH, 32'h203);

    // bus timeout: ack withheld for the whole window
    drive(OP_SW, 32'h300, 32'hCAFE_F00D, 1'b1, 5'd3, 32'h0);
    @(negedge clk);
    for (int i = 0; i < T - 1; i++) begin
      check("to.stall", 32'(stall_req), 32'd1);
      check("to.req", 32'(mem_req), 32'd1);
      @(negedge clk);
    end
    check("to.stall_last", 32'(stall_req), 32'd0);
    check("to.no_err_yet", 32'(bus_err), 32'd0);
    nop();
    @(negedge clk);
    check("to.bus_err", 32'(bus_err), 32'd1);
    check("to.req_drop", 32'(mem_req), 32'd0);
    check("to.wb_we", 32'(is_write_WB), 32'd0);
    @(negedge clk);
    check("to.err_pulse", 32'(bus_err), 32'd0);
    $display("store sw addr=300 timed out after %0d wait cycles", T);

    // reset during WAIT, with non-zero WB register contents beforehand
    drive(8'h01, 32'h0, 32'h0, 1'b1, 5'd5, 32'h1234);
    @(negedge clk);
    drive(OP_LW, 32'h400, 32'h0, 1'b1, 5'd9, 32'h0);
    @(negedge clk);
    check("rw.req", 32'(mem_req), 32'd1);
    #1 reset = 1'b0;
    #1;
    check("rw.req_drop", 32'(mem_req), 32'd0);
    check("rw.stall_drop", 32'(stall_req), 32'd0);
    check("rw.wb_rd", 32'(write_regAddress_WB), 32'd0);
    check("rw.wb_val", write_regValue_WB, 32'h0);
    @(negedge clk);
    nop();
    reset     = 1'b1;
    mem_ack   = 1'b1;
    mem_rdata = 32'h7777_7777;
    @(negedge clk);
    mem_ack = 1'b0;
    check("rw.late_we", 32'(is_write_WB), 32'd0);
    check("rw.late_val", write_regValue_WB, 32'h0);
    check("rw.late_req", 32'(mem_req), 32'd0);
    $display("reset mid-access, late ack ignored");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
